bus_master: RTL and testbench

Requester-side endpoint of the shared two-master bus: accepts one command (single or burst, read or write) from local logic and raises a bus request. It waits for the arbiter's registered grant, then holds the bus by driving busy while it performs every beat against the slave. Afterwards it releases the bus. Two instances, one per master port, sit opposite the arbiter's request/grant pairs and together source the arbiter's busbusy.

---
 rtl/bus_pkg.sv | 16 +
 rtl/bus_timeout_counter.sv | 30 +++
 rtl/bus_master.sv | 148 ++++++++++++++
 tb/tb_bus_master.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared bus definitions: master state encoding and default bus widths used by
// the arbiter, masters and slaves.
package bus_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned LEN_W  = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    XFER    = 2'd2,
    RELEASE = 2'd3
  } bus_state_e;

endpackage

// File: rtl/bus_timeout_counter.sv
// Per-beat wait counter: counts stalled cycles and flags the cycle in which
// the LIMIT-th consecutive stall occurs.
module bus_timeout_counter #(
  parameter int unsigned LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count,
  output logic expire
);

  localparam int unsigned CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (count) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // The stall being counted right now is the LIMIT-th one.
  assign expire = count && (cnt == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/bus_master.sv
// Requester-side endpoint of the shared two-master bus: one command per
// request/grant/transfer/release round trip. Optional beat timeout under
// BUS_MASTER_TIMEOUT_EN.
module bus_master #(
  parameter int unsigned ADDR_W = bus_pkg::ADDR_W,
  parameter int unsigned DATA_W = bus_pkg::DATA_W,
  parameter int unsigned LEN_W  = bus_pkg::LEN_W
`ifdef BUS_MASTER_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT = 15
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_pop,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              done,
  output logic              err,
  output logic              bus_req,
  input  logic              bus_grant,
  output logic              bus_busy,
  output logic              bus_valid,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ready
);

  import bus_pkg::*;

  bus_state_e        state;
  bus_state_e        state_nx;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  left_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              abort_q;
  logic              accept_c;
  logic              beat_c;
  logic              last_c;
  logic              expire_c;

  assign accept_c = (state == IDLE) && cmd_valid;
  assign beat_c   = (state == XFER) && bus_ready;
  assign last_c   = beat_c && (left_q == '0);

`ifdef BUS_MASTER_TIMEOUT_EN
  // Cleared outside XFER and on every completed beat, so each beat gets a fresh budget.
  bus_timeout_counter #(
    .LIMIT (TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  ((state != XFER) || bus_ready),
    .count  ((state == XFER) && !bus_ready),
    .expire (expire_c)
  );
`else
  assign expire_c = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state and state-decoded outputs.
  always_comb begin
    state_nx  = state;
    cmd_ready = 1'b0;
    bus_req   = 1'b0;
    bus_busy  = 1'b0;
    bus_valid = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    wr_pop    = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = rst;
        if (cmd_valid) state_nx = REQ;
      end
      REQ: begin
        bus_req = 1'b1;
        if (bus_grant) state_nx = XFER;
      end
      XFER: begin
        bus_req   = 1'b1;
        bus_busy  = 1'b1;
        bus_valid = 1'b1;
        bus_we    = we_q;
        bus_addr  = addr_q;
        bus_wdata = we_q ? wr_data : '0;
        wr_pop    = we_q && bus_ready;
        if (last_c || expire_c) state_nx = RELEASE;
      end
      RELEASE: begin
        done     = !abort_q;
        err      = abort_q;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Command latch, beat address/count and registered read response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q        <= 1'b0;
      addr_q      <= '0;
      left_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      abort_q     <= 1'b0;
    end else begin
      rsp_valid_q <= beat_c && !we_q;
      if (beat_c && !we_q) rsp_data_q <= bus_rdata;
      if (accept_c) begin
        we_q    <= cmd_we;
        addr_q  <= cmd_addr;
        left_q  <= cmd_len;
        abort_q <= 1'b0;
      end else if (beat_c) begin
        addr_q <= addr_q + ADDR_W'(1);
        if (!last_c) left_q <= left_q - LEN_W'(1);
      end
      if (expire_c) abort_q <= 1'b1;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_bus_master.sv
// Bench for bus_master: two masters behind a small registered-grant arbiter,
// master 0 checked every cycle against a transaction-level model.
module tb_bus_master;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned LW = 3;
`ifdef BUS_MASTER_TIMEOUT_EN
  localparam int TO = 15;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          cmd_valid0, cmd_ready0, cmd_we0, wr_pop0, rsp_valid0, done0, err0;
  logic [AW-1:0] cmd_addr0, bus_addr0;
  logic [LW-1:0] cmd_len0;
  logic [DW-1:0] wr_data0, rsp_data0, bus_wdata0, bus_rdata0;
  logic          bus_req0, bus_grant0, bus_busy0, bus_valid0, bus_we0, bus_ready0;

  logic          cmd_valid1, cmd_ready1, cmd_we1, wr_pop1, rsp_valid1, done1, err1;
  logic [AW-1:0] cmd_addr1, bus_addr1;
  logic [LW-1:0] cmd_len1;
  logic [DW-1:0] wr_data1, rsp_data1, bus_wdata1, bus_rdata1;
  logic          bus_req1, bus_grant1, bus_busy1, bus_valid1, bus_we1, bus_ready1;

  bus_master u0 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0), .cmd_we(cmd_we0),
    .cmd_addr(cmd_addr0), .cmd_len(cmd_len0), .wr_data(wr_data0), .wr_pop(wr_pop0),
    .rsp_valid(rsp_valid0), .rsp_data(rsp_data0), .done(done0), .err(err0),
    .bus_req(bus_req0), .bus_grant(bus_grant0), .bus_busy(bus_busy0), .bus_valid(bus_valid0),
    .bus_we(bus_we0), .bus_addr(bus_addr0), .bus_wdata(bus_wdata0), .bus_rdata(bus_rdata0),
    .bus_ready(bus_ready0)
  );

  bus_master u1 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1), .cmd_we(cmd_we1),
    .cmd_addr(cmd_addr1), .cmd_len(cmd_len1), .wr_data(wr_data1), .wr_pop(wr_pop1),
    .rsp_valid(rsp_valid1), .rsp_data(rsp_data1), .done(done1), .err(err1),
    .bus_req(bus_req1), .bus_grant(bus_grant1), .bus_busy(bus_busy1), .bus_valid(bus_valid1),
    .bus_we(bus_we1), .bus_addr(bus_addr1), .bus_wdata(bus_wdata1), .bus_rdata(bus_rdata1),
    .bus_ready(bus_ready1)
  );

  // Arbiter: registered grant, master 0 has priority, no grant while the bus is busy.
  logic [1:0] arb_g;
  always @(posedge clk or negedge rst) begin
    if (!rst) arb_g <= 2'b00;
    else if (bus_busy0 || bus_busy1) arb_g <= 2'b00;
    else arb_g <= {bus_req1 && !bus_req0, bus_req0};
  end
  assign bus_grant0 = arb_g[0];
  assign bus_grant1 = arb_g[1];

  // Slave 0: mode 0 zero-wait, mode 1 two wait cycles per beat, mode 2 never ready.
  logic [1:0] slv_mode;
  logic [1:0] wcnt;
  always @(posedge clk or negedge rst) begin
    if (!rst) wcnt <= 2'd0;
    else if (!bus_valid0 || bus_ready0) wcnt <= 2'd0;
    else wcnt <= wcnt + 2'd1;
  end
  assign bus_ready0 = (slv_mode == 2'd0) ? 1'b1 : (slv_mode == 2'd1) ? (wcnt == 2'd2) : 1'b0;
  assign bus_rdata0 = (bus_addr0 == 16'h0010) ? 16'hBEEF : (bus_addr0 ^ 16'h5A5A);

  // Write source for master 0: first-word-fall-through sequence 0xA1, 0xA2, ...
  int pop_cnt = 0;
  always @(posedge clk) if (wr_pop0) pop_cnt <= pop_cnt + 1;
  assign wr_data0 = 16'h00A1 + 16'(pop_cnt);

  assign bus_ready1 = 1'b1;
  assign bus_rdata1 = 16'h1111;
  assign wr_data1   = 16'h2222;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  // Transaction-level model of master 0.
  bit            m_cmd;
  bit            m_owner;
  bit            m_closing;
  bit            m_aborted;
  bit            m_we;
  logic [AW-1:0] m_addr;
  int            m_beats;
  int            m_waits;
  bit            m_rsp_v;
  logic [DW-1:0] m_rsp_d;

  // Observations.
  int acc_cyc, req_cyc, val_cyc, rsp_cyc, done_cyc, err_cyc;
  int busy_n, pop_n, rsp_n, done_n, err_n;
  int req1_n, busy1_cyc, done1_n, done1_cyc;
  logic [DW-1:0] rsp1_last;
  logic [AW-1:0] addr_log[$];
  logic [DW-1:0] wdata_log[$];
  logic [DW-1:0] rsp_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_cmd = 0; m_owner = 0; m_closing = 0; m_aborted = 0; m_we = 0;
    m_addr = '0; m_beats = 0; m_waits = 0; m_rsp_v = 0; m_rsp_d = '0;
  endtask

  task automatic clear_obs();
    acc_cyc = -1; req_cyc = -1; val_cyc = -1; rsp_cyc = -1; done_cyc = -1; err_cyc = -1;
    busy_n = 0; pop_n = 0; rsp_n = 0; done_n = 0; err_n = 0;
    req1_n = 0; busy1_cyc = -1; done1_n = 0; done1_cyc = -1; rsp1_last = '0;
    addr_log.delete(); wdata_log.delete(); rsp_log.delete();
  endtask

  task automatic compare_outputs();
    chk("cmd_ready", cmd_ready0, rst && !m_cmd);
    chk("bus_req", bus_req0, m_cmd && !m_closing);
    chk("bus_busy", bus_busy0, m_owner);
    chk("bus_valid", bus_valid0, m_owner);
    chk("bus_we", bus_we0, m_owner && m_we);
    chk("bus_addr", bus_addr0, m_owner ? m_addr : 16'h0);
    chk("bus_wdata", bus_wdata0, (m_owner && m_we) ? wr_data0 : 16'h0);
    chk("wr_pop", wr_pop0, m_owner && m_we && bus_ready0);
    chk("rsp_valid", rsp_valid0, m_rsp_v);
    chk("rsp_data", rsp_data0, m_rsp_d);
    chk("done", done0, m_closing && !m_aborted);
    chk("err", err0, m_closing && m_aborted);
    chk("busy_overlap", bus_busy0 && bus_busy1, 1'b0);
  endtask

  task automatic observe();
    if (cmd_valid0 && cmd_ready0) acc_cyc = cyc;
    if (bus_req0 && req_cyc < 0) req_cyc = cyc;
    if (bus_valid0 && val_cyc < 0) val_cyc = cyc;
    if (bus_busy0) busy_n++;
    if (wr_pop0) pop_n++;
    if (rsp_valid0) begin rsp_n++; rsp_cyc = cyc; rsp_log.push_back(rsp_data0); end
    if (done0) begin done_n++; done_cyc = cyc; end
    if (err0) begin err_n++; err_cyc = cyc; end
    if (bus_valid0 && bus_ready0) begin
      addr_log.push_back(bus_addr0);
      wdata_log.push_back(bus_wdata0);
    end
    if (bus_req1) req1_n++;
    if (bus_busy1 && busy1_cyc < 0) busy1_cyc = cyc;
    if (done1) begin done1_n++; done1_cyc = cyc; end
    if (rsp_valid1) rsp1_last = rsp_data1;
  endtask

  // Advance the model by one clock using the inputs that were present at the edge.
  task automatic model_update(input bit cv, input bit cwe, input logic [AW-1:0] ca,
                              input logic [LW-1:0] cl, input bit g, input bit rdy,
                              input logic [DW-1:0] rd);
    bit nv;
    nv = 0;
    if (m_closing) begin
      m_cmd = 0; m_closing = 0;
    end else if (!m_cmd) begin
      if (cv) begin
        m_cmd = 1; m_owner = 0; m_aborted = 0; m_we = cwe; m_addr = ca; m_beats = int'(cl) + 1;
      end
    end else if (!m_owner) begin
      if (g) begin m_owner = 1; m_waits = 0; end
    end else if (rdy) begin
      if (!m_we) begin nv = 1; m_rsp_d = rd; end
      m_addr = m_addr + 16'd1;
      m_beats--;
      m_waits = 0;
      if (m_beats == 0) begin m_owner = 0; m_closing = 1; end
    end else begin
`ifdef BUS_MASTER_TIMEOUT_EN
      m_waits++;
      if (m_waits == TO) begin m_owner = 0; m_closing = 1; m_aborted = 1; end
`endif
    end
    m_rsp_v = nv;
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic step();
    bit cv, cwe, g, rdy;
    logic [AW-1:0] ca;
    logic [LW-1:0] cl;
    logic [DW-1:0] rd;
    #1;
    compare_outputs();
    observe();
    cv = cmd_valid0; cwe = cmd_we0; ca = cmd_addr0; cl = cmd_len0;
    g = bus_grant0; rdy = bus_ready0; rd = bus_rdata0;
    @(posedge clk);
    model_update(cv, cwe, ca, cl, g, rdy, rd);
    @(negedge clk);
    cyc++;
  endtask

  task automatic issue0(input bit we, input logic [AW-1:0] addr, input logic [LW-1:0] len);
    cmd_valid0 = 1'b1; cmd_we0 = we; cmd_addr0 = addr; cmd_len0 = len;
    step();
    cmd_valid0 = 1'b0;
    chk("cmd_accept", acc_cyc >= 0, 1'b1);
  endtask

  task automatic run_until_end(input int bound);
    int k;
    k = 0;
    while ((done_n + err_n) == 0 && k < bound) begin step(); k++; end
    chk("end_within_bound", k < bound, 1'b1);
    repeat (2) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    cmd_valid0 = 0; cmd_we0 = 0; cmd_addr0 = '0; cmd_len0 = '0;
    cmd_valid1 = 0; cmd_we1 = 0; cmd_addr1 = '0; cmd_len1 = '0;
    slv_mode = 2'd0;
    model_reset();
    clear_obs();

    repeat (2) @(negedge clk);
    #1;
    chk("reset_cmd_ready", cmd_ready0, 1'b0);
    chk("reset_bus_req", bus_req0, 1'b0);
    chk("reset_done", done0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) step();

    // Single zero-wait read of 0x0010.
    clear_obs();
    issue0(1'b0, 16'h0010, 3'd0);
    run_until_end(30);
    chk("single_req_lat", req_cyc - acc_cyc, 1);
    chk("single_valid_lat", val_cyc - acc_cyc, 3);
    chk("single_busy_cycles", busy_n, 1);
    chk("single_rsp_count", rsp_n, 1);
    chk("single_rsp_data", rsp_log[0], 16'hBEEF);
    chk("single_rsp_lat", rsp_cyc - val_cyc, 1);
    chk("single_done_lat", done_cyc - val_cyc, 1);
    chk("single_done_count", done_n, 1);

    // Write burst wrapping the address space.
    clear_obs();
    issue0(1'b1, 16'hFFFE, 3'd3);
    run_until_end(40);
    chk("wburst_pops", pop_n, 4);
    chk("wburst_done", done_n, 1);
    chk("wburst_beats", addr_log.size(), 4);
    if (addr_log.size() == 4) begin
      chk("wburst_addr0", addr_log[0], 16'hFFFE);
      chk("wburst_addr1", addr_log[1], 16'hFFFF);
      chk("wburst_addr2", addr_log[2], 16'h0000);
      chk("wburst_addr3", addr_log[3], 16'h0001);
      chk("wburst_data0", wdata_log[0], 16'h00A1);
      chk("wburst_data3", wdata_log[3], 16'h00A4);
    end

    // Read burst against a slave with two wait cycles per beat.
    clear_obs();
    slv_mode = 2'd1;
    issue0(1'b0, 16'h0100, 3'd1);
    run_until_end(40);
    slv_mode = 2'd0;
    chk("wait_busy_cycles", busy_n, 6);
    chk("wait_rsp_count", rsp_n, 2);
    if (rsp_log.size() == 2) begin
      chk("wait_rsp0", rsp_log[0], 16'h5B5A);
      chk("wait_rsp1", rsp_log[1], 16'h5B5B);
    end

    // Both masters command in the same cycle; master 0 wins.
    clear_obs();
    cmd_valid1 = 1'b1; cmd_we1 = 1'b0; cmd_addr1 = 16'h0030; cmd_len1 = 3'd0;
    cmd_valid0 = 1'b1; cmd_we0 = 1'b0; cmd_addr0 = 16'h0020; cmd_len0 = 3'd0;
    step();
    cmd_valid0 = 1'b0; cmd_valid1 = 1'b0;
    begin
      int k;
      k = 0;
      while (done1_n == 0 && k < 40) begin step(); k++; end
      chk("arb_end_within_bound", k < 40, 1'b1);
    end
    repeat (2) step();
    chk("arb_winner_done", done_n, 1);
    chk("arb_loser_done", done1_n, 1);
    chk("arb_order", done_cyc < done1_cyc, 1'b1);
    chk("arb_loser_busy_after_release", busy1_cyc - done_cyc, 2);
    chk("arb_loser_req_cycles", req1_n, 6);
    chk("arb_loser_rsp", rsp1_last, 16'h1111);

    // Asynchronous reset in the middle of an 8-beat read burst.
    clear_obs();
    issue0(1'b0, 16'h0200, 3'd7);
    begin
      int k;
      k = 0;
      while (addr_log.size() < 3 && k < 30) begin step(); k++; end
      chk("rst_reach_xfer", k < 30, 1'b1);
    end
    #2;
    rst = 1'b0;
    #1;
    chk("arst_bus_req", bus_req0, 1'b0);
    chk("arst_bus_busy", bus_busy0, 1'b0);
    chk("arst_bus_valid", bus_valid0, 1'b0);
    chk("arst_bus_addr", bus_addr0, 16'h0);
    chk("arst_cmd_ready", cmd_ready0, 1'b0);
    chk("arst_rsp_valid", rsp_valid0, 1'b0);
    chk("arst_done", done0, 1'b0);
    chk("arst_err", err0, 1'b0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) step();
    chk("arst_no_done", done_n + err_n, 0);

    // Normal command after reset.
    clear_obs();
    issue0(1'b1, 16'h0300, 3'd0);
    run_until_end(30);
    chk("post_rst_done", done_n, 1);
    chk("post_rst_pops", pop_n, 1);
    if (addr_log.size() == 1) begin
      chk("post_rst_addr", addr_log[0], 16'h0300);
      chk("post_rst_wdata", wdata_log[0], 16'h00A5);
    end else begin
      chk("post_rst_beats", addr_log.size(), 1);
    end

`ifdef BUS_MASTER_TIMEOUT_EN
    // Slave never ready: the command aborts after 15 stalled cycles.
    clear_obs();
    slv_mode = 2'd2;
    issue0(1'b0, 16'h0400, 3'd2);
    run_until_end(60);
    slv_mode = 2'd0;
    chk("to_err", err_n, 1);
    chk("to_done", done_n, 0);
    chk("to_rsp", rsp_n, 0);
    chk("to_busy_cycles", busy_n, 15);
    chk("to_err_lat", err_cyc - val_cyc, 15);
`endif

    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
